// File: rtl/pa_riscv.sv
`default_nettype none
// ============================================================================
//  Module      : pa_riscv (package)
//  Description : Shared types for the instruction fetch path: queue entry
//                layout and fetch-queue FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pa_riscv;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] c_PC_STEP = 32'd4;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // IDLE: no request; WAIT: request outstanding, data kept;
    // DROP: request outstanding, returning data discarded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fq_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_storage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_storage
//  Description : Circular buffer of fetch entries with read/write pointers
//                and an occupancy counter. Flush empties the buffer.
//                The caller guarantees no push when full and no pop when
//                empty unless a pop happens in the same cycle as the push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_storage
    import pa_riscv::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fq_entry_t                i_pushEntry,
    input  logic                     i_pop,
    output fq_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    // Buffer array, pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_pushEntry;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction prefetch queue. Issues one outstanding word read
//                at a time, never letting entries plus outstanding requests
//                exceed DEPTH, and discards in-flight data after a redirect.
//                Optional macro FETCH_QUEUE_BYPASS_EN forwards returning data
//                straight to the core when the queue is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import pa_riscv::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_srst,
    output logic        o_memReq,
    output logic [31:0] o_memAddr,
    input  logic        i_memAck,
    input  logic [31:0] i_memData,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instrPc,
    input  logic        i_instrReady,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t      r_state;
    fq_state_t      w_stateNext;
    logic           r_memReq;
    logic           w_memReqNext;
    logic [31:0]    r_memAddr;
    logic [31:0]    w_memAddrNext;
    logic [31:0]    r_fetchPc;
    logic [31:0]    w_fetchPcNext;

    fq_entry_t      w_head;
    fq_entry_t      w_pushEntry;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_occNext;
    logic [31:0]    w_redirPc;
    logic           w_unusedRedirLsb;
    logic           w_ack;
    logic           w_accept;
    logic           w_empty;
    logic           w_bypass;
    logic           w_valid;
    logic           w_pop;
    logic           w_popStore;
    logic           w_push;
    logic           w_room;

    // Redirect targets are always fetched word-aligned.
    assign w_redirPc        = {i_redirectPc[31:2], 2'b00};
    assign w_unusedRedirLsb = ^i_redirectPc[1:0];

    // An ack only counts while a request is actually outstanding.
    assign w_ack    = i_memAck & (r_state != ST_IDLE);
    assign w_accept = (r_state == ST_WAIT) & w_ack & ~i_redirect;
    assign w_empty  = (w_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_accept & w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the core takes immediately never enters storage.
    assign w_valid     = ~w_empty | w_bypass;
    assign w_pop       = w_valid & i_instrReady & ~i_redirect;
    assign w_popStore  = w_pop & ~w_bypass;
    assign w_push      = w_accept & ~(w_bypass & w_pop);
    assign w_occNext   = w_count + CW'(w_push) - CW'(w_popStore);
    assign w_room      = (w_occNext < CW'(DEPTH));

    assign w_pushEntry = '{pc: r_memAddr, instr: i_memData};

    fetch_queue_storage #(
        .DEPTH       (DEPTH)
    ) u_storage (
        .i_clk       (i_clk),
        .i_srst      (i_srst),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_popStore),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Next state, next request and next fetch address; defaults hold everything.
    always_comb begin
        w_stateNext   = r_state;
        w_memReqNext  = r_memReq;
        w_memAddrNext = r_memAddr;
        w_fetchPcNext = r_fetchPc;
        case (r_state)
            ST_IDLE: begin
                if (i_redirect) begin
                    w_fetchPcNext = w_redirPc;
                end else if (w_count < CW'(DEPTH)) begin
                    w_stateNext   = ST_WAIT;
                    w_memReqNext  = 1'b1;
                    w_memAddrNext = r_fetchPc;
                end
            end
            ST_WAIT: begin
                if (w_ack && i_redirect) begin
                    // Queue is flushed this cycle, so credit is always available.
                    w_fetchPcNext = w_redirPc;
                    w_memAddrNext = w_redirPc;
                end else if (w_ack) begin
                    w_fetchPcNext = r_fetchPc + c_PC_STEP;
                    if (w_room) begin
                        w_memAddrNext = r_fetchPc + c_PC_STEP;
                    end else begin
                        w_stateNext  = ST_IDLE;
                        w_memReqNext = 1'b0;
                    end
                end else if (i_redirect) begin
                    w_stateNext   = ST_DROP;
                    w_fetchPcNext = w_redirPc;
                end
            end
            ST_DROP: begin
                // Queue stays empty while dropping, so the next request can issue.
                if (w_ack) begin
                    w_stateNext   = ST_WAIT;
                    w_memReqNext  = 1'b1;
                    w_fetchPcNext = i_redirect ? w_redirPc : r_fetchPc;
                    w_memAddrNext = i_redirect ? w_redirPc : r_fetchPc;
                end else if (i_redirect) begin
                    w_fetchPcNext = w_redirPc;
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_memReqNext = 1'b0;
            end
        endcase
    end

    // FSM state, request and address registers.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state   <= ST_IDLE;
            r_memReq  <= 1'b0;
            r_memAddr <= RESET_PC;
            r_fetchPc <= RESET_PC;
        end else begin
            r_state   <= w_stateNext;
            r_memReq  <= w_memReqNext;
            r_memAddr <= w_memAddrNext;
            r_fetchPc <= w_fetchPcNext;
        end
    end

    assign o_memReq     = r_memReq;
    assign o_memAddr    = r_memAddr;
    assign o_instrValid = w_valid;
    assign o_instr      = w_bypass ? i_memData : w_head.instr;
    assign o_instrPc    = w_bypass ? r_memAddr : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed scenarios plus randomized traffic for fetch_queue,
//                checked against a transaction-level queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        memAck = 1'b0;
    logic        instrReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] memData = '0;
    logic [31:0] redirectPc = '0;
    logic        memReq;
    logic        instrValid;
    logic [31:0] memAddr;
    logic [31:0] instr;
    logic [31:0] instrPc;

    int   total = 0;
    int   bad   = 0;
    logic force_dead = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH        (DEPTH),
        .RESET_PC     (RESET_PC)
    ) dut (
        .i_clk        (clk),
        .i_srst       (srst),
        .o_memReq     (memReq),
        .o_memAddr    (memAddr),
        .i_memAck     (memAck),
        .i_memData    (memData),
        .o_instrValid (instrValid),
        .o_instr      (instr),
        .o_instrPc    (instrPc),
        .i_instrReady (instrReady),
        .i_redirect   (redirect),
        .i_redirectPc (redirectPc)
    );

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, return at the falling edge.
    task automatic tick(input logic s, input logic a, input logic r, input logic d,
                        input logic [31:0] rpc);
        @(posedge clk);
        #1;
        srst       = s;
        memAck     = a;
        instrReady = r;
        redirect   = d;
        redirectPc = rpc;
        memData    = force_dead ? 32'hDEAD_BEEF : memf(memAddr);
        @(negedge clk);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic        live = 1'b0;
    logic        prevReq = 1'b0;
    logic        prevAck = 1'b0;
    logic        prevSrst = 1'b1;
    logic [31:0] prevAddr = '0;
    logic [31:0] expPc = RESET_PC;
    logic        m_acc, m_byp, m_ev, m_pop;

    always @(negedge clk) begin
        if (mon_en) begin
            if (srst) begin
                q_pc.delete();
                q_in.delete();
                live  = 1'b0;
                expPc = RESET_PC;
            end else begin
                if (prevReq && !prevAck && !prevSrst) begin
                    chk("hold_req", memReq, 1'b1);
                    chk("hold_addr", memAddr, prevAddr);
                end
                chk("credit", (q_pc.size() + (memReq ? 1 : 0) <= DEPTH), 1'b1);
                // A request is live unless a redirect occurs while it is outstanding.
                if (memReq && (!prevReq || prevAck)) live = 1'b1;
                if (memReq && redirect) live = 1'b0;
                m_acc = memReq && memAck && live;
                if (m_acc) begin
                    chk("fetch_addr", memAddr, expPc);
                    expPc = expPc + 32'd4;
                end
                m_byp = (BYP == 1) && m_acc && (q_pc.size() == 0);
                m_ev  = (q_pc.size() != 0) || m_byp;
                chk("valid", instrValid, m_ev);
                if (m_ev) begin
                    chk("head_pc", instrPc, m_byp ? memAddr : q_pc[0]);
                    chk("head_instr", instr, m_byp ? memData : q_in[0]);
                end
                m_pop = m_ev && instrReady && !redirect;
                if (m_pop && !m_byp) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (m_acc && !(m_byp && m_pop)) begin
                    q_pc.push_back(memAddr);
                    q_in.push_back(memData);
                end
                if (redirect) begin
                    q_pc.delete();
                    q_in.delete();
                    expPc = {redirectPc[31:2], 2'b00};
                end
            end
            prevReq  = memReq;
            prevAck  = memReq & memAck;
            prevAddr = memAddr;
            prevSrst = srst;
        end
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int   acks;
        logic found;

        // Reset values
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        mon_en = 1'b1;
        chk("rst_req", memReq, 1'b0);
        chk("rst_valid", instrValid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instrPc, 32'h0);

        // Streaming with zero-wait memory; first request on the second cycle
        tick(0, 1, 1, 0, 0);
        chk("first_req_c0", memReq, 1'b0);
        tick(0, 1, 1, 0, 0);
        chk("first_req_c1", memReq, 1'b1);
        chk("first_addr", memAddr, RESET_PC);
        chk("bypass_latency", instrValid, (BYP == 1));
        for (int i = BYP; i < BYP + 8; i++) begin
            tick(0, 1, 1, 0, 0);
            chk("stream_valid", instrValid, 1'b1);
            chk("stream_pc", instrPc, 32'(i * 4));
        end

        // Core stalled: exactly DEPTH acks, then fetch resumes at 0x10
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 0, 0, 0);
            if (memReq && memAck) acks++;
        end
        chk("full_acks", acks, DEPTH);
        chk("full_req_low", memReq, 1'b0);
        tick(0, 1, 1, 0, 0);
        chk("resume_head", instrPc, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, 1, 1, 0, 0);
            found = memReq;
        end
        chk("resume_found", found, 1'b1);
        chk("resume_addr", memAddr, 32'h10);

        // Redirect while waiting; late ack data must be dropped
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 32'h100);
        chk("drop_req", memReq, 1'b1);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("drop_hold_addr", memAddr, 32'h0);
        force_dead = 1'b1;
        tick(0, 1, 1, 0, 0);
        force_dead = 1'b0;
        chk("drop_no_valid", instrValid, 1'b0);
        tick(0, 1, 1, 0, 0);
        chk("drop_next_addr", memAddr, 32'h100);
        found = instrValid;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, 1, 1, 0, 0);
            found = instrValid;
        end
        chk("drop_found", found, 1'b1);
        chk("drop_pc", instrPc, 32'h100);
        chk("drop_instr", instr, memf(32'h100));

        // Redirect coincident with ack and pop
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 32'h103);
        chk("coinc_valid", instrValid, 1'b1);
        chk("coinc_req", memReq, 1'b1);
        tick(0, 0, 1, 0, 0);
        chk("coinc_flushed", instrValid, 1'b0);
        chk("coinc_req_next", memReq, 1'b1);
        chk("coinc_addr", memAddr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, 1, 1, 0, 0);
            found = instrValid;
        end
        chk("coinc_found", found, 1'b1);
        chk("coinc_pc", instrPc, 32'h100);

        // Reset during an outstanding request, with an ack in the reset cycle
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        chk("rreq_pending", memReq, 1'b1);
        tick(1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rreq_req", memReq, 1'b0);
        chk("rreq_valid", instrValid, 1'b0);
        chk("rreq_instr", instr, 32'h0);
        chk("rreq_pc", instrPc, 32'h0);
        tick(0, 0, 0, 0, 0);
        chk("rreq_first", memReq, 1'b1);
        chk("rreq_addr", memAddr, RESET_PC);

        // Randomized traffic against the model
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
